uart_receiver: RTL and testbench

8N1 UART receive stage, the downstream counterpart of the design's Transmitter: it consumes the serial line that a Transmitter drives (TxD → RxD) and returns parallel bytes. The serial input is synchronised and start-bit validated. Each bit is sampled at mid-bit with a baud counter, and a one-cycle strobe is raised for every good frame or for every framing error. The block sits between the board's RX pin and any byte consumer (loopback checker, command decoder).

---
 rtl/uart_receiver.sv | 138 +++++++++++++
 tb/tb_uart_receiver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronises RxD, validates the start bit, samples mid-bit, strobes per frame.
// Optional build macro RX_MAJORITY_VOTE_EN: each bit decision becomes a 3-sample majority of rx_s.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RxD,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_error,
   output logic       busy
);

   localparam logic [13:0] HALF_M1 = 14'(CLKS_PER_BIT / 2 - 1);
   localparam logic [13:0] FULL_M1 = 14'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t      state;
   logic        rx_meta;
   logic        rx_s;
   logic        rx_d;
   logic [13:0] counter;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;
   logic        sample_bit;

   // Flops reset high so an idle line never looks like a start edge out of reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= RxD;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

`ifdef RX_MAJORITY_VOTE_EN
   logic [1:0] rx_hist;

   // rx_hist[0] and rx_hist[1] hold rx_s from the two cycles before the sample point.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         rx_hist <= 2'b11;
      end else begin
         rx_hist <= {rx_hist[0], rx_s};
      end
   end

   assign sample_bit = (rx_hist[1] & rx_hist[0]) |
                       (rx_hist[1] & rx_s) |
                       (rx_hist[0] & rx_s);
`else
   assign sample_bit = rx_s;
`endif

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state       <= IDLE;
         counter     <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         data        <= '0;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
         busy        <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
         case (state)
            IDLE: begin
               counter <= '0;
               if (rx_d && !rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (counter == HALF_M1) begin
                  counter <= '0;
                  if (!sample_bit) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  counter <= counter + 14'd1;
               end
            end
            DATA: begin
               if (counter == FULL_M1) begin
                  shift_reg <= {sample_bit, shift_reg[7:1]};
                  counter   <= '0;
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  counter <= counter + 14'd1;
               end
            end
            STOP: begin
               // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
               if (counter == FULL_M1) begin
                  if (sample_bit) begin
                     data       <= shift_reg;
                     data_valid <= 1'b1;
                  end else begin
                     frame_error <= 1'b1;
                  end
                  state   <= IDLE;
                  busy    <= 1'b0;
                  counter <= '0;
               end else begin
                  counter <= counter + 14'd1;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               counter <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLKS_PER_BIT=16: reset, single byte, back-to-back,
// glitch, break, mid-frame reset and mid-bit pulse rejection.
module tb_uart_receiver;

   localparam int T = 16;
   localparam int H = T / 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       RxD   = 1'b1;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_error;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int dv_count = 0;
   int fe_count = 0;
   int both_count = 0;
   int dv_cycle = 0;
   int dv_cycle_prev = 0;
   int start_cycle = 0;
   logic [7:0] dv_data = 8'h00;
   logic [7:0] dv_data_prev = 8'h00;

   uart_receiver #(.CLKS_PER_BIT(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RxD         (RxD),
      .data        (data),
      .data_valid  (data_valid),
      .frame_error (frame_error),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Strobe monitor on the falling edge, well away from the active edge.
   always @(negedge clk) begin
      if (data_valid) begin
         dv_count++;
         dv_data_prev  = dv_data;
         dv_data       = data;
         dv_cycle_prev = dv_cycle;
         dv_cycle      = cycle;
      end
      if (frame_error) fe_count++;
      if (data_valid && frame_error) both_count++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int value, input int lo, input int hi);
      checks++;
      assert (value >= lo && value <= hi) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, value, lo, hi);
      end
   endtask

   // Drives one frame LSB first; glitch inverts RxD for one clock at offset H of each data bit,
   // which lands on the receiver's sample point; abort_bit >= 0 asserts reset mid data bit.
   task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit,
                                 input logic glitch, input int abort_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < T; c++) begin
            @(posedge clk);
            #1;
            if (i == 0 && c == 0) start_cycle = cycle;
            if (abort_bit >= 0 && i == abort_bit + 1 && c == H) begin
               rst_n = 1'b1;
               RxD   = 1'b1;
               tick(3);
               rst_n = 1'b0;
               return;
            end
            RxD = (glitch && i >= 1 && i <= 8 && c == H) ? ~frame[i] : frame[i];
         end
      end
   endtask

   initial begin
      $display("[TB] reset and idle");
      tick(5);
      check_output("rst_data", data, 8'h00);
      check_output("rst_valid", data_valid, 1'b0);
      check_output("rst_ferr", frame_error, 1'b0);
      check_output("rst_busy", busy, 1'b0);
      rst_n = 1'b0;
      tick(5);
      check_output("idle_data", data, 8'h00);
      check_output("idle_busy", busy, 1'b0);
      check_output("idle_strobes", dv_count + fe_count, 0);

      $display("[TB] single byte 0xA5");
      apply_stimulus(8'hA5, 1'b1, 1'b0, -1);
      tick(4);
      check_output("a5_count", dv_count, 1);
      check_output("a5_data", data, 8'hA5);
      check_output("a5_strobe_data", dv_data, 8'hA5);
      check_output("a5_ferr", fe_count, 0);
      check_range("a5_latency", dv_cycle - start_cycle, 9 * T + H + 2, 9 * T + H + 4);
      check_output("a5_busy", busy, 1'b0);

      $display("[TB] back-to-back 0x00 0xFF");
      tick(T);
      apply_stimulus(8'h00, 1'b1, 1'b0, -1);
      apply_stimulus(8'hFF, 1'b1, 1'b0, -1);
      tick(4);
      check_output("b2b_count", dv_count, 3);
      check_output("b2b_first", dv_data_prev, 8'h00);
      check_output("b2b_second", dv_data, 8'hFF);
      check_output("b2b_data", data, 8'hFF);
      check_range("b2b_spacing", dv_cycle - dv_cycle_prev, 10 * T - 1, 10 * T + 1);

      $display("[TB] start glitch");
      tick(T);
      RxD = 1'b0;
      tick(4);
      check_output("glitch_busy_hi", busy, 1'b1);
      RxD = 1'b1;
      tick(H + 4);
      check_output("glitch_busy_lo", busy, 1'b0);
      check_output("glitch_strobes", dv_count + fe_count, 3);

      $display("[TB] break frame 0x3C");
      tick(T);
      apply_stimulus(8'h3C, 1'b0, 1'b0, -1);
      RxD = 1'b1;
      tick(4);
      check_output("brk_ferr", fe_count, 1);
      check_output("brk_valid", dv_count, 3);
      check_output("brk_data", data, 8'hFF);
      tick(T);

      $display("[TB] reset mid-frame");
      apply_stimulus(8'h5A, 1'b1, 1'b0, 4);
      check_output("abort_busy", busy, 1'b0);
      check_output("abort_data", data, 8'h00);
      check_output("abort_strobes", dv_count + fe_count, 4);
      tick(T);
      apply_stimulus(8'h81, 1'b1, 1'b0, -1);
      tick(4);
      check_output("post_count", dv_count, 4);
      check_output("post_data", data, 8'h81);
      check_output("post_strobe_data", dv_data, 8'h81);

      $display("[TB] mid-bit pulses on 0x55");
      tick(T);
      apply_stimulus(8'h55, 1'b1, 1'b1, -1);
      tick(4);
      check_output("pulse_count", dv_count, 5);
`ifdef RX_MAJORITY_VOTE_EN
      check_output("vote_data", data, 8'h55);
`else
      check_output("novote_data", data, 8'hAA);
      check_output("novote_not55", data != 8'h55, 1'b1);
`endif
      check_output("never_both", both_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
